core_mem_arb: RTL

//  Arbitrates one shared memory bus between the instruction-fetch port (I) and the load/store port (D).
//  The D port is driven by the MEM stage with the address and strobe produced by the load/store address unit.

---
 rtl/core_mem_arb.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/core_mem_arb.sv
// core_mem_arb
//   Shares one memory bus between the instruction-fetch port (I) and the
//   load/store port (D). A granted request is latched into the M_* registers.
//   The bus then runs a valid/ready handshake. The read data goes back to the
//   owner with a single-cycle READY pulse.
//   Data accesses win by default. A one-shot fairness flag hands the next
//   grant to a waiting fetch after a data grant, so fetch cannot starve.
//
// Ports
//   CLK, NRST          clock (rising edge), synchronous active-low reset
//   I_VALID/I_ADDR     fetch request (held until I_READY)
//   I_READY/I_RDATA    fetch completion pulse and fetched word
//   D_VALID/D_WE/D_ADDR/D_STRB/D_WDATA  load/store request (held until D_READY)
//   D_READY/D_RDATA    load/store completion pulse and raw load word
//   M_VALID/M_WE/M_ADDR/M_STRB/M_WDATA  bus request (stable while M_VALID)
//   M_READY/M_RDATA    bus completion and read data
//   ERR                one-cycle bus-timeout pulse, aligned with the READY pulse
//
// Configuration
//   MEMARB_TIMEOUT_EN  when defined, a 16-bit counter aborts a bus access after
//                      TIMEOUT_CYCLES stalled cycles. The owner then gets READY
//                      with RDATA=0, and ERR pulses. When undefined, the arbiter
//                      waits for M_READY indefinitely and ERR is tied to 0.

module core_mem_arb #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              I_VALID,
  input  logic [AW-1:0]     I_ADDR,
  output logic              I_READY,
  output logic [DW-1:0]     I_RDATA,
  input  logic              D_VALID,
  input  logic              D_WE,
  input  logic [AW-1:0]     D_ADDR,
  input  logic [DW/8-1:0]   D_STRB,
  input  logic [DW-1:0]     D_WDATA,
  output logic              D_READY,
  output logic [DW-1:0]     D_RDATA,
  output logic              M_VALID,
  output logic              M_WE,
  output logic [AW-1:0]     M_ADDR,
  output logic [DW/8-1:0]   M_STRB,
  output logic [DW-1:0]     M_WDATA,
  input  logic              M_READY,
  input  logic [DW-1:0]     M_RDATA,
  output logic              ERR
);

  localparam int SW = DW / 8;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  // Clears the byte offset so that fetches are always word aligned.
  localparam logic [AW-1:0] WORD_MASK = ~{{(AW-2){1'b0}}, 2'b11};

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("core_mem_arb: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

  state_t          state_q, state_d;
  logic            own_q, own_d;
  logic            fair_q, fair_d;
  logic            m_valid_q, m_valid_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [SW-1:0]   m_strb_q, m_strb_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            d_win;

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // D takes the grant unless fetch is waiting and was passed over last time.
  assign d_win = D_VALID & ~(I_VALID & fair_q);

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q   <= IDLE;
      own_q     <= OWN_I;
      fair_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_strb_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      fair_q    <= fair_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_strb_q  <= m_strb_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    fair_d    = fair_q;
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_strb_d  = m_strb_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEMARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (d_win) begin
          own_d     = OWN_D;
          fair_d    = I_VALID;
          m_valid_d = 1'b1;
          m_we_d    = D_WE;
          m_addr_d  = D_ADDR;
          m_strb_d  = D_STRB;
          m_wdata_d = D_WDATA;
          state_d   = DBUS;
`ifdef MEMARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else if (I_VALID) begin
          own_d     = OWN_I;
          fair_d    = 1'b0;
          m_valid_d = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = I_ADDR & WORD_MASK;
          m_strb_d  = '1;
          m_wdata_d = '0;
          state_d   = IBUS;
`ifdef MEMARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      IBUS, DBUS: begin
        if (m_valid_q && M_READY) begin
          m_valid_d = 1'b0;
          if (own_q == OWN_D) d_rdata_d = M_RDATA;
          else                i_rdata_d = M_RDATA;
          state_d = RESP;
        end
`ifdef MEMARB_TIMEOUT_EN
        // This stalled cycle is the TIMEOUT_CYCLES-th one: abort the access.
        else if (m_valid_q && (cnt_q == TO_LAST)) begin
          m_valid_d = 1'b0;
          if (own_q == OWN_D) d_rdata_d = '0;
          else                i_rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (m_valid_q) begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // READY is derived from registered state, so only one port can see it.
  assign I_READY = (state_q == RESP) && (own_q == OWN_I);
  assign D_READY = (state_q == RESP) && (own_q == OWN_D);
  assign I_RDATA = i_rdata_q;
  assign D_RDATA = d_rdata_q;
  assign M_VALID = m_valid_q;
  assign M_WE    = m_we_q;
  assign M_ADDR  = m_addr_q;
  assign M_STRB  = m_strb_q;
  assign M_WDATA = m_wdata_q;
`ifdef MEMARB_TIMEOUT_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
